// File: rtl/mandel_view_loader_if.sv
// Configuration bus between the host pin block and the viewport loader.
// master drives the pin-side inputs and frame pulse; slave is the loader.
interface mandel_view_loader_if #(
  parameter int BITS    = 16,
  parameter int IN_BITS = 14
);
  logic [IN_BITS-1:0] value_in;
  logic               sel_y;
  logic               strobe;
  logic               frame_start;
  logic [BITS-1:0]    x_left;
  logic [BITS-1:0]    y_top;
  logic [BITS-1:0]    x_inc;
  logic [BITS-1:0]    y_inc;
  logic               pending;
  logic               committed;

  modport master (
    output value_in, sel_y, strobe, frame_start,
    input  x_left, y_top, x_inc, y_inc, pending, committed
  );

  modport slave (
    input  value_in, sel_y, strobe, frame_start,
    output x_left, y_top, x_inc, y_inc, pending, committed
  );
endinterface

// File: rtl/mandel_view_loader.sv
// Viewport loader: synchronises host pin writes into shadow registers and
// commits them atomically to the renderer at a frame boundary.
//
// Per-axis write pointer:
//   state      | meaning
//   PTR_ORIGIN | next write targets the origin shadow (pair complete)
//   PTR_INC    | next write targets the increment shadow (pair half-written)
module mandel_view_loader #(
  parameter int BITS        = 16,
  parameter int IN_BITS     = 14,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  mandel_view_loader_if.slave cfg
);
  localparam logic [BITS-1:0] X_LEFT_RST = BITS'(16'hA800);  // -11 << 11
  localparam logic [BITS-1:0] Y_TOP_RST  = BITS'(16'h3400);  //  13 << 10
  localparam logic [BITS-1:0] X_INC_RST  = BITS'(16'h00F0);
  localparam logic [BITS-1:0] Y_INC_RST  = BITS'(16'h0033);

  typedef enum logic {PTR_ORIGIN = 1'b0, PTR_INC = 1'b1} ptr_t;

  logic [IN_BITS-1:0]     r_val_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_sel_sync;
  logic [SYNC_STAGES-1:0] r_stb_sync;
  logic                   r_stb_d;

  ptr_t r_ptr_x, r_ptr_y, w_ptr_x_nxt, w_ptr_y_nxt;

  logic [BITS-1:0] r_x_left_s, r_y_top_s, r_x_inc_s, r_y_inc_s;
  logic [BITS-1:0] r_x_left, r_y_top, r_x_inc, r_y_inc;
  logic            r_pending, r_committed;

  logic               w_write, w_wr_x, w_wr_y, w_commit;
  logic [IN_BITS-1:0] w_val;
  logic [BITS-1:0]    w_origin, w_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_val_sync[i] <= '0;
      r_sel_sync <= '0;
      r_stb_sync <= '0;
      r_stb_d    <= 1'b0;
    end else begin
      r_val_sync[0] <= cfg.value_in;
      r_sel_sync[0] <= cfg.sel_y;
      r_stb_sync[0] <= cfg.strobe;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_val_sync[i] <= r_val_sync[i-1];
        r_sel_sync[i] <= r_sel_sync[i-1];
        r_stb_sync[i] <= r_stb_sync[i-1];
      end
      r_stb_d <= r_stb_sync[SYNC_STAGES-1];
    end
  end

  assign w_val   = r_val_sync[SYNC_STAGES-1];
  assign w_write = r_stb_sync[SYNC_STAGES-1] & ~r_stb_d;
  // Origin: [1:-12] pin format widened to [2:-13]; increment stays raw LSBs.
  assign w_origin = {{(BITS-IN_BITS-1){w_val[IN_BITS-1]}}, w_val, 1'b0};
  assign w_inc    = {{(BITS-IN_BITS){1'b0}}, w_val};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr_x <= PTR_ORIGIN;
      r_ptr_y <= PTR_ORIGIN;
    end else begin
      r_ptr_x <= w_ptr_x_nxt;
      r_ptr_y <= w_ptr_y_nxt;
    end
  end

  always_comb begin
    w_ptr_x_nxt = r_ptr_x;
    w_ptr_y_nxt = r_ptr_y;
    w_wr_x      = w_write & ~r_sel_sync[SYNC_STAGES-1];
    w_wr_y      = w_write &  r_sel_sync[SYNC_STAGES-1];
    w_commit    = cfg.frame_start & r_pending &
                  (r_ptr_x == PTR_ORIGIN) & (r_ptr_y == PTR_ORIGIN);
    if (w_wr_x) w_ptr_x_nxt = (r_ptr_x == PTR_ORIGIN) ? PTR_INC : PTR_ORIGIN;
    if (w_wr_y) w_ptr_y_nxt = (r_ptr_y == PTR_ORIGIN) ? PTR_INC : PTR_ORIGIN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x_left_s  <= X_LEFT_RST;
      r_y_top_s   <= Y_TOP_RST;
      r_x_inc_s   <= X_INC_RST;
      r_y_inc_s   <= Y_INC_RST;
      r_x_left    <= X_LEFT_RST;
      r_y_top     <= Y_TOP_RST;
      r_x_inc     <= X_INC_RST;
      r_y_inc     <= Y_INC_RST;
      r_pending   <= 1'b0;
      r_committed <= 1'b0;
    end else begin
      if (w_wr_x && r_ptr_x == PTR_ORIGIN) r_x_left_s <= w_origin;
      if (w_wr_x && r_ptr_x == PTR_INC)    r_x_inc_s  <= w_inc;
      if (w_wr_y && r_ptr_y == PTR_ORIGIN) r_y_top_s  <= w_origin;
      if (w_wr_y && r_ptr_y == PTR_INC)    r_y_inc_s  <= w_inc;
      // Commit copies pre-write shadows; a same-edge write wins on pending.
      if (w_commit) begin
        r_x_left <= r_x_left_s;
        r_y_top  <= r_y_top_s;
        r_x_inc  <= r_x_inc_s;
        r_y_inc  <= r_y_inc_s;
      end
      if (w_write)       r_pending <= 1'b1;
      else if (w_commit) r_pending <= 1'b0;
      r_committed <= w_commit;
    end
  end

  assign cfg.x_left    = r_x_left;
  assign cfg.y_top     = r_y_top;
  assign cfg.x_inc     = r_x_inc;
  assign cfg.y_inc     = r_y_inc;
  assign cfg.pending   = r_pending;
  assign cfg.committed = r_committed;
endmodule

// File: tb/tb_mandel_view_loader.sv
// Self-checking bench for mandel_view_loader: width-rule table, directed
// corner sequences and randomized writes/frames against a behavioural model.
module tb_mandel_view_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mandel_view_loader_if #(.BITS(16), .IN_BITS(14)) bus();

  mandel_view_loader #(.BITS(16), .IN_BITS(14), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cfg  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: index [axis][0=origin,1=increment], axis 0 = X, 1 = Y.
  logic [15:0] m_sh  [2][2];
  logic [15:0] m_out [2][2];
  bit          m_ptr [2];
  bit          m_pend;

  typedef struct {
    bit          sel;
    logic [13:0] org_in;
    logic [13:0] inc_in;
    logic [15:0] exp_org;
    logic [15:0] exp_inc;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] origin_of(logic [13:0] v);
    int s;
    s = v[13] ? int'(v) - 16384 : int'(v);
    return 16'(s * 2);
  endfunction

  function automatic logic [15:0] inc_of(logic [13:0] v);
    return 16'(int'(v));
  endfunction

  function automatic void model_reset();
    m_sh[0][0] = 16'hA800; m_sh[0][1] = 16'h00F0;
    m_sh[1][0] = 16'h3400; m_sh[1][1] = 16'h0033;
    m_out  = m_sh;
    m_ptr[0] = 0; m_ptr[1] = 0;
    m_pend = 0;
  endfunction

  function automatic void model_write(bit sel, logic [13:0] v);
    if (!m_ptr[sel]) m_sh[sel][0] = origin_of(v);
    else             m_sh[sel][1] = inc_of(v);
    m_ptr[sel] = !m_ptr[sel];
    m_pend = 1;
  endfunction

  task automatic check_outputs(string tag);
    chk({tag, ".x_left"},  bus.x_left,  m_out[0][0]);
    chk({tag, ".x_inc"},   bus.x_inc,   m_out[0][1]);
    chk({tag, ".y_top"},   bus.y_top,   m_out[1][0]);
    chk({tag, ".y_inc"},   bus.y_inc,   m_out[1][1]);
    chk({tag, ".pending"}, 16'(bus.pending), 16'(m_pend));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.strobe = 1'b0; bus.frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_write(bit sel, logic [13:0] v, int hold);
    @(negedge clk);
    bus.value_in = v; bus.sel_y = sel;
    repeat (3) @(negedge clk);
    bus.strobe = 1'b1;
    repeat (hold) @(negedge clk);
    bus.strobe = 1'b0;
    repeat (4) @(negedge clk);
    model_write(sel, v);
  endtask

  task automatic do_frame(string tag);
    bit exp_c;
    exp_c = m_pend && !m_ptr[0] && !m_ptr[1];
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    if (exp_c) begin
      m_out  = m_sh;
      m_pend = 0;
    end
    chk({tag, ".committed"}, 16'(bus.committed), 16'(exp_c));
    check_outputs(tag);
    @(negedge clk);
    chk({tag, ".committed_drop"}, 16'(bus.committed), 16'h0);
  endtask

  // Write event lands on the same edge as frame_start.
  task automatic do_collide(bit sel, logic [13:0] v);
    bit exp_c;
    @(negedge clk);
    bus.value_in = v; bus.sel_y = sel;
    repeat (3) @(negedge clk);
    bus.strobe = 1'b1;
    repeat (2) @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.strobe = 1'b0;
    exp_c = m_pend && !m_ptr[0] && !m_ptr[1];
    if (exp_c) m_out = m_sh;
    model_write(sel, v);
    chk("collide.committed", 16'(bus.committed), 16'(exp_c));
    check_outputs("collide");
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{0, 14'h3000, 14'h0078, 16'hE000, 16'h0078};
    vecs[1] = '{1, 14'h0800, 14'h0019, 16'h1000, 16'h0019};
    vecs[2] = '{0, 14'h1FFF, 14'h3FFF, 16'h3FFE, 16'h3FFF};
    vecs[3] = '{1, 14'h2000, 14'h0001, 16'hC000, 16'h0001};
    vecs[4] = '{0, 14'h0000, 14'h2ABC, 16'h0000, 16'h2ABC};
    vecs[5] = '{1, 14'h3FFF, 14'h0000, 16'hFFFE, 16'h0000};

    rst_n = 1'b0;
    bus.value_in = '0; bus.sel_y = 1'b0;
    bus.strobe = 1'b0; bus.frame_start = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    chk("rst.x_left",    bus.x_left,  16'hA800);
    chk("rst.y_top",     bus.y_top,   16'h3400);
    chk("rst.x_inc",     bus.x_inc,   16'h00F0);
    chk("rst.y_inc",     bus.y_inc,   16'h0033);
    chk("rst.pending",   16'(bus.pending),   16'h0);
    chk("rst.committed", 16'(bus.committed), 16'h0);

    // Nothing pending: frame does nothing.
    do_frame("idle_frame");

    // Width-rule table: full pair then commit, checked against fixed values.
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].sel, vecs[i].org_in, 1);
      chk("tbl.pending_set", 16'(bus.pending), 16'h1);
      do_write(vecs[i].sel, vecs[i].inc_in, 2);
      do_frame("tbl");
      if (vecs[i].sel) begin
        chk("tbl.y_top", bus.y_top, vecs[i].exp_org);
        chk("tbl.y_inc", bus.y_inc, vecs[i].exp_inc);
      end else begin
        chk("tbl.x_left", bus.x_left, vecs[i].exp_org);
        chk("tbl.x_inc",  bus.x_inc,  vecs[i].exp_inc);
      end
    end

    // Incomplete Y pair is held, then completed.
    do_write(1, 14'h0800, 1);
    do_frame("incomplete");
    chk("incomplete.pending", 16'(bus.pending), 16'h1);
    do_write(1, 14'h0019, 1);
    do_frame("completed");
    chk("completed.y_top", bus.y_top, 16'h1000);
    chk("completed.y_inc", bus.y_inc, 16'h0019);

    // Long strobe counts once: ptr_x left at 1, frame must not commit.
    do_write(0, 14'h1FFF, 20);
    do_frame("long_strobe");
    do_write(0, 14'h0042, 1);
    do_frame("long_strobe_done");
    chk("long.x_left", bus.x_left, 16'h3FFE);
    chk("long.x_inc",  bus.x_inc,  16'h0042);

    // Collision: X pair committed, Y origin write lands same edge.
    do_write(0, 14'h3000, 1);
    do_write(0, 14'h0078, 1);
    do_collide(1, 14'h0400);
    chk("collide.x_left", bus.x_left, 16'hE000);
    chk("collide.pending", 16'(bus.pending), 16'h1);
    do_write(1, 14'h0005, 1);
    do_frame("collide_after");
    chk("collide_after.y_top", bus.y_top, 16'h0800);

    // Reset mid-pair discards the half-written origin.
    do_write(0, 14'h1234, 1);
    do_reset();
    check_outputs("midrst");
    do_write(0, 14'h0400, 1);
    do_write(0, 14'h0010, 1);
    do_frame("midrst_after");
    chk("midrst.x_left", bus.x_left, 16'h0800);

    // Randomized writes and frames against the model.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 7)
        do_write(1'($urandom_range(0, 1)), 14'($urandom),
                 int'($urandom_range(1, 5)));
      else
        do_frame("rand");
    end
    if (m_ptr[0]) do_write(0, 14'($urandom), 1);
    if (m_ptr[1]) do_write(1, 14'($urandom), 1);
    do_frame("rand_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mandel_view_loader.md
Name: mandel_view_loader

Overview:
- Host-side configuration receiver for the Mandelbrot renderer.
- Accepts viewport origin and step values from the asynchronous input pins (ui_in plus uio_in) through a strobe protocol.
- Holds the values in shadow registers and commits them atomically to the renderer's x_left / y_top / x_inc / y_inc at a frame boundary.
- Output values are consumed directly by the pixel-iteration logic. Reset values reproduce the built-in default view.

Parameters:
- BITS, 16, width of renderer fixed-point coordinates (signed, format [2:-(BITS-3)]).
- IN_BITS, 14, width of pin value bus (signed, format [1:-(IN_BITS-2)]).
- SYNC_STAGES, 2, flops in each input synchroniser.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- value_in  in  IN_BITS  pin data {uio_in[5:0], ui_in}, asynchronous
- sel_y  in  1  pin uio_in[6]: 0 = X axis write, 1 = Y axis write, asynchronous
- strobe  in  1  pin uio_in[7]: write strobe, asynchronous, rising edge active
- frame_start  in  1  one-cycle pulse from the VGA timing block (vsync_pulse)
- x_left  out  BITS  committed left edge
- y_top  out  BITS  committed top edge
- x_inc  out  BITS  committed per-pixel X step, raw LSBs
- y_inc  out  BITS  committed per-row Y step, raw LSBs
- pending  out  1  shadow differs from committed (a write is awaiting commit)
- committed  out  1  one-cycle pulse on the cycle after a commit

Behaviour:
- Reset: one clock with rst_n=0. All outputs and state take reset values:
  - x_left=16'hA800 (-11<<11), y_top=16'h3400 (13<<10), x_inc=16'h00F0, y_inc=16'h0033
  - shadows equal to those values
  - pending=0, committed=0, ptr_x=0, ptr_y=0
  - synchroniser flops and the edge-detect flop cleared to 0
- Synchronisation: value_in, sel_y and strobe each pass through SYNC_STAGES flops. One extra flop delays synced strobe for edge detection.
- Write event: synced strobe=1 and delayed strobe=0.
  - Fires exactly once per pin rising edge, regardless of how long strobe is held high.
  - The shadow is written on the 3rd clock edge after the first edge that samples strobe high (SYNC_STAGES=2).
  - The host keeps value_in and sel_y stable from 3 clocks before the strobe rise until 3 clocks after it.
- Per-axis pointer (1 bit each), selected by sel_y:
  - ptr=0: write the origin shadow (x_left_s or y_top_s), then set ptr=1.
  - ptr=1: write the increment shadow (x_inc_s or y_inc_s), then set ptr=0.
  - Each write sets pending=1.
- Width rules:
  - Origin = sign-extend value_in by one bit, append one zero LSB. Result is {v[13],v[13:0],1'b0}, format [2:-13].
  - Increment = value_in zero-extended to BITS, raw LSB units, unsigned.
- Commit: when frame_start=1, pending=1, ptr_x=0 and ptr_y=0, all four outputs load from the shadows in the same edge.
  - pending clears to 0 on that edge.
  - committed=1 on the following cycle only.
  - frame_start with pending=0, or with either ptr=1 (incomplete pair), does nothing. The shadows are held for a later frame.
- Simultaneous write event and frame_start:
  - The commit decision and the committed values use the pre-write state (shadows and pointers before this edge).
  - The write still lands in the shadow.
  - pending ends at 1: set by the write, which overrides the clear.
- Outputs change only at commit or reset, never mid-frame.
- Reset mid-sequence (ptr=1): all state returns to reset values. A half-written pair is discarded.
- No further write-event decoding happens during reset.

Test Plan:
- Reset: hold rst_n=0 for 1 cycle -> x_left=16'hA800, y_top=16'h3400, x_inc=16'h00F0, y_inc=16'h0033, pending=0, committed=0.
- X pair load: sel_y=0, write 14'h3000 then 14'h0078, then pulse frame_start -> x_left=16'hE000, x_inc=16'h0078, y outputs unchanged, committed pulses 1 cycle after, pending 1->0.
- Incomplete pair: sel_y=1, single write 14'h0800, frame_start -> no output change, pending=1. Second write 14'h0019, next frame_start -> y_top=16'h1000, y_inc=16'h0019.
- Long strobe: hold strobe high 20 cycles with 14'h1FFF, sel_y=0 -> exactly one write, ptr_x=1. frame_start then gives no commit.
- Collision: complete X pair, then a Y origin write event on the same edge as frame_start -> X values commit, the Y write lands in the shadow, pending=1, no Y output change.
- Reset mid-sequence: X origin written (ptr_x=1), assert rst_n=0 -> all defaults restored. A following X write lands in x_left_s (ptr_x was cleared).
